pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It compares source-register demand in ID against producers in EX and MEM using Tuse/Tnew, and tracks the multi-cycle mult/div unit with a busy countdown. It drives the IF-stage Stall input, which freezes the PC and the IF/ID register, and bubbles ID/EX. It also keeps a stall-cycle performance counter.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu issues
DIV_CYC, 10, busy cycles after a div/divu issues
CNT_W, 4, width of the MD countdown; must hold DIV_CYC

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
rs_d  in  5  rs field of the instruction in ID
rt_d  in  5  rt field of the instruction in ID
tuse_rs_d  in  2  cycles until ID needs rs; 3 = not used
tuse_rt_d  in  2  cycles until ID needs rt; 3 = not used
md_use_d  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
dst_e  in  5  destination register of the instruction in EX
we_e  in  1  EX instruction writes the GPR file
tnew_e  in  2  cycles until the EX result is forwardable
dst_m  in  5  destination register of the instruction in MEM
we_m  in  1  MEM instruction writes the GPR file
tnew_m  in  2  cycles until the MEM result is forwardable
md_start_e  in  1  a mult/div is in EX this cycle (one-cycle pulse)
md_div_e  in  1  qualifies md_start_e: 1 = div/divu, 0 = mult/multu
stall  out  1  to IF Stall: hold PC and IF/ID
flush_e  out  1  clear ID/EX to a nop this cycle
md_busy  out  1  MD countdown is nonzero
md_err  out  1  sticky: md_start_e seen while busy
stall_cnt  out  32  count of stalled cycles since reset

Behaviour:
- stall is combinational from the inputs and registered state, so it takes effect in the same cycle. flush_e = stall.
- Register hazard for rs, with E/M in both terms:
  - term E: rs_d != 0 && we_e && dst_e == rs_d && tuse_rs_d < tnew_e
  - term M: the same test using dst_m, we_m, tnew_m.
  - rt uses the identical test with rt_d and tuse_rt_d.
  - Register 0 never causes a stall.
  - tuse = 3 never stalls, because tnew is at most 2.
- MD hazard: md_use_d && (md_start_e || md_busy).
- stall = any register hazard || MD hazard.
- MD countdown register cnt (CNT_W bits); FSM has two states: IDLE (cnt == 0) and BUSY (cnt != 0).
  - IDLE and md_start_e: cnt <= md_div_e ? DIV_CYC : MULT_CYC.
  - BUSY: cnt <= cnt - 1 each cycle, so BUSY lasts exactly N cycles.
  - BUSY and md_start_e: the start is ignored, the countdown continues, and md_err <= 1. md_err stays set until reset.
- md_busy = (cnt != 0).
- Timing example: mult in EX at cycle t with mflo in ID. mflo is stalled for cycles t through t+MULT_CYC (6 cycles) and enters EX at t+MULT_CYC+1.
- stall is independent of whether md_start_e and stall coincide. The MD instruction in EX proceeds; only ID and earlier freeze.
- stall_cnt increments on every cycle where stall = 1 and wraps modulo 2^32.
- Reset values: cnt = 0, md_busy = 0, md_err = 0, stall_cnt = 0.
- During a reset cycle, stall and flush_e are forced to 0.
- Reset in the middle of a countdown clears cnt immediately; the next cycle is IDLE.
- Inputs marked X for a bubble must arrive with we_* = 0 and md_start_e = 0. The stage registers guarantee this.

Decomposition:
- Shared package / CPU_Param.v holds:
  - TUSE_NONE = 2'd3
  - MULT_CYC and DIV_CYC defaults
  - the Tnew encodings for ALU (1), load (2), and no-write/already-ready (0).
- Sub-module md_busy_timer: the cnt register, load/decrement logic, md_busy and md_err.
- The comparator logic stays in the top module as one function-style combinational block, reused for rs and rt.

Test Plan:
- lw $1 in EX (we_e=1, dst_e=1, tnew_e=2) while add in ID has rs_d=1, tuse_rs_d=1 → stall=1, flush_e=1 for 1 cycle. Next cycle (M, tnew_m=1) → stall=0.
- Same stimulus with rs_d=rt_d=0 and dst_e=0 → stall=0 every cycle; stall_cnt unchanged.
- md_start_e=1, md_div_e=0, with mflo in ID (md_use_d=1) → stall=1 for exactly 6 cycles, md_busy high for 5; then stall=0 and stall_cnt=6.
- div start then mfhi: md_busy high 10 cycles. A second md_start_e at busy cycle 3 → md_err=1 and the countdown is not reloaded (ends on cycle 10).
- reset asserted at busy cycle 4 of a div → next cycle: md_busy=0, md_err=0, stall_cnt=0, stall=0.
- E term and M term both true for rs and rt simultaneously → single stall=1 per cycle; stall_cnt increments by 1, not 2.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline hazard definitions: Tuse/Tnew encodings, mult/div latencies,
// MD timer state encoding and the producer bundle compared against ID sources.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned TU_W  = 2;

  localparam logic [TU_W-1:0] TUSE_NONE = 2'd3;
  localparam logic [TU_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [TU_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TU_W-1:0] TNEW_LOAD = 2'd2;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // One downstream stage that may be producing a GPR value
  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic             we;
    logic [TU_W-1:0]  tnew;
  } producer_t;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy countdown: loads the unit latency on an idle start, counts down
// to zero, and flags (sticky) any start that arrives while still counting.
module md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic err
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          cnt_d   = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          state_d = (cnt_d != '0) ? MD_BUSY : MD_IDLE;
        end
      end
      MD_BUSY: begin
        // A start while counting is dropped; the running countdown wins
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_IDLE;
        if (start) err_d = 1'b1;
      end
    endcase
  end

  assign busy = (cnt_q != '0);
  assign err  = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: Tuse/Tnew register hazards from EX and MEM,
// mult/div busy hazard, and a free-running stalled-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [TU_W-1:0]  tuse_rs_d,
  input  logic [TU_W-1:0]  tuse_rt_d,
  input  logic             md_use_d,
  input  logic [REG_W-1:0] dst_e,
  input  logic             we_e,
  input  logic [TU_W-1:0]  tnew_e,
  input  logic [REG_W-1:0] dst_m,
  input  logic             we_m,
  input  logic [TU_W-1:0]  tnew_m,
  input  logic             md_start_e,
  input  logic             md_div_e,
  output logic             stall,
  output logic             flush_e,
  output logic             md_busy,
  output logic             md_err,
  output logic [31:0]      stall_cnt
);

  producer_t prod_e, prod_m;
  logic      hz_rs, hz_rt, hz_md;

  assign prod_e = '{dst: dst_e, we: we_e, tnew: tnew_e};
  assign prod_m = '{dst: dst_m, we: we_m, tnew: tnew_m};

  // $0 never stalls; TUSE_NONE exceeds any Tnew so it drops out of the compare
  function automatic logic reg_hazard(input logic [REG_W-1:0] src,
                                      input logic [TU_W-1:0]  tuse,
                                      input producer_t        p);
    return (src != '0) && p.we && (p.dst == src) && (tuse < p.tnew);
  endfunction

  md_busy_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_e),
    .is_div (md_div_e),
    .busy   (md_busy),
    .err    (md_err)
  );

  always_comb begin
    hz_rs   = reg_hazard(rs_d, tuse_rs_d, prod_e) || reg_hazard(rs_d, tuse_rs_d, prod_m);
    hz_rt   = reg_hazard(rt_d, tuse_rt_d, prod_e) || reg_hazard(rt_d, tuse_rt_d, prod_m);
    hz_md   = md_use_d && (md_start_e || md_busy);
    stall   = !reset && (hz_rs || hz_rt || hz_md);
    flush_e = stall;
  end

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule
